// File: rtl/cacheline_adapter.sv
// cacheline_adapter: bridges the L1 cache's 256-bit line port to a 64-bit burst
// memory port. Fills collect beats into one line; writebacks split a dirty line
// into beats and send them in order. Only one transaction is in flight at a time.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a cache request; memory strobes are ignored
// RD_BURST | read request to memory, collecting beats on resp_i
// RD_DONE  | one-cycle completion pulse, assembled line on line_o
// WR_BURST | write request to memory, presenting beats on burst_o
// WR_DONE  | one-cycle completion pulse for the writeback
module cacheline_adapter #(
    parameter  int s_line    = 256,
    parameter  int s_burst   = 64,
    localparam int num_beats = s_line / s_burst,
    localparam int s_cnt     = $clog2(num_beats)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [s_line-1:0]   line_i,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic [s_line-1:0]   line_o,
    output logic                resp_o,
    input  logic [s_burst-1:0]  burst_i,
    input  logic                resp_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o
);

    localparam int               OFF  = $clog2(s_line / 8);
    localparam logic [s_cnt-1:0] LAST = s_cnt'(num_beats - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        RD_DONE  = 3'd2,
        WR_BURST = 3'd3,
        WR_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [s_cnt-1:0]    r_cnt;
    logic [s_line-1:0]   r_buf;
    logic [s_line-1:0]   r_line;
    logic [31:0]         r_addr;
    logic [s_line-1:0]   w_buf_fill;
    logic [31:0]         w_addr_aligned;
    logic                w_last_beat;

    assign w_addr_aligned = {address_i[31:OFF], {OFF{1'b0}}};
    assign w_last_beat    = resp_i && (r_cnt == LAST);

    // Buffer with the incoming read beat merged into the current slot.
    always_comb begin
        w_buf_fill = r_buf;
        w_buf_fill[r_cnt*s_burst +: s_burst] = burst_i;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a writeback takes priority over a fill.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_state_next = WR_BURST;
                end else if (read_i) begin
                    w_state_next = RD_BURST;
                end
            end
            RD_BURST: if (w_last_beat) w_state_next = RD_DONE;
            WR_BURST: if (w_last_beat) w_state_next = WR_DONE;
            RD_DONE:  w_state_next = IDLE;
            WR_DONE:  w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // Datapath: request latching, beat counting and line assembly.
    // The counter holds on the last beat so it never wraps mid-transaction.
    // line_o has its own register so a writeback never disturbs the last fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_buf  <= '0;
            r_line <= '0;
            r_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (write_i) begin
                        r_buf  <= line_i;
                        r_addr <= w_addr_aligned;
                        r_cnt  <= '0;
                    end else if (read_i) begin
                        r_addr <= w_addr_aligned;
                        r_cnt  <= '0;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        r_buf <= w_buf_fill;
                        if (r_cnt == LAST) begin
                            r_line <= w_buf_fill;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (resp_i && (r_cnt != LAST)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the state; memory-side buses are zero outside bursts.
    always_comb begin
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        address_o = '0;
        burst_o   = '0;
        case (r_state)
            RD_BURST: begin
                read_o    = 1'b1;
                address_o = r_addr;
            end
            WR_BURST: begin
                write_o   = 1'b1;
                address_o = r_addr;
                burst_o   = r_buf[r_cnt*s_burst +: s_burst];
            end
            RD_DONE:  resp_o = 1'b1;
            WR_DONE:  resp_o = 1'b1;
            default: ;
        endcase
    end

    assign line_o = r_line;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed fills/writebacks from the
// plan, then randomized transactions against a line-level reference model.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic         resp_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: the line the cache should currently see on line_o.
    logic [255:0] m_line;

    always #5 clk = ~clk;

    cacheline_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) l = {l[223:0], 32'($urandom)};
        return l;
    endfunction

    // Strobe choice: mode 0 back-to-back, 1 random, 2 fixed pattern (bit i = cycle i).
    function automatic logic pick_resp(input int mode, input int cyc, input logic [15:0] pat);
        if (mode == 0) return 1'b1;
        if (mode == 2) return (cyc < 16) ? pat[cyc] : 1'b1;
        if (cyc > 20) return 1'b1;
        return ($urandom_range(0, 2) != 0);
    endfunction

    task automatic finish_txn(input string tag);
        resp_i = 1'b0;
        check({tag, " resp_o in done"}, 256'(resp_o), 256'(1'b1));
        check({tag, " req low in done"}, 256'({read_o, write_o}), 256'(2'b00));
        check({tag, " line_o in done"}, line_o, m_line);
        read_i  = 1'b0;
        write_i = 1'b0;
        step();
        check({tag, " resp_o after"}, 256'(resp_o), 256'(1'b0));
        check({tag, " line_o held"}, line_o, m_line);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [63:0] beats [4],
                           input int mode, input logic [15:0] pat, input int exp_cycles);
        int k;
        int cyc;
        logic r;
        check({tag, " idle before"}, 256'({read_o, write_o, resp_o}), 256'(3'b000));
        read_i    = 1'b1;
        address_i = addr;
        step();
        k   = 0;
        cyc = 0;
        while (k < 4 && cyc < 64) begin
            check({tag, " read_o"}, 256'(read_o), 256'(1'b1));
            check({tag, " resp_o early"}, 256'(resp_o), 256'(1'b0));
            check({tag, " address_o"}, 256'(address_o), 256'(addr & 32'hFFFF_FFE0));
            r       = pick_resp(mode, cyc, pat);
            resp_i  = r;
            burst_i = r ? beats[k] : rand64();
            step();
            if (r) k++;
            cyc++;
        end
        if (exp_cycles > 0) check({tag, " read cycles"}, 256'(cyc), 256'(exp_cycles));
        m_line = {beats[3], beats[2], beats[1], beats[0]};
        finish_txn(tag);
    endtask

    task automatic do_write(input string tag, input logic [255:0] line, input logic [31:0] addr,
                            input logic also_read, input int mode);
        logic [63:0]  q[$];
        logic [255:0] sh;
        int cyc;
        logic r;
        for (int i = 0; i < 4; i++) begin
            sh = line >> (64 * i);
            q.push_back(sh[63:0]);
        end
        check({tag, " idle before"}, 256'({read_o, write_o, resp_o}), 256'(3'b000));
        write_i   = 1'b1;
        read_i    = also_read;
        line_i    = line;
        address_i = addr;
        step();
        line_i = rand256();
        cyc    = 0;
        while (q.size() > 0 && cyc < 64) begin
            check({tag, " write_o"}, 256'(write_o), 256'(1'b1));
            check({tag, " read_o low"}, 256'(read_o), 256'(1'b0));
            check({tag, " address_o"}, 256'(address_o), 256'(addr & 32'hFFFF_FFE0));
            check({tag, " burst_o"}, 256'(burst_o), 256'(q[0]));
            check({tag, " resp_o early"}, 256'(resp_o), 256'(1'b0));
            r       = pick_resp(mode, cyc, 16'h0);
            resp_i  = r;
            burst_i = rand64();
            step();
            if (r) void'(q.pop_front());
            cyc++;
        end
        finish_txn(tag);
    endtask

    initial begin
        logic [63:0]  bts [4];
        logic [255:0] wl;
        rst       = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        m_line    = '0;

        step();
        step();
        check("reset line_o", line_o, 256'(0));
        check("reset ctrl", 256'({read_o, write_o, resp_o}), 256'(3'b000));
        check("reset burst_o", 256'(burst_o), 256'(0));
        check("reset address_o", 256'(address_o), 256'(0));
        rst = 1'b1;
        step();

        bts[0] = 64'h1111_1111_1111_1111;
        bts[1] = 64'h2222_2222_2222_2222;
        bts[2] = 64'h3333_3333_3333_3333;
        bts[3] = 64'h4444_4444_4444_4444;
        do_read("rd_b2b", 32'h0000_1234, bts, 0, 16'h0, 4);
        do_read("rd_stall", 32'h0000_1234, bts, 2, 16'b101_1001, 7);

        wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        do_write("wr_basic", wl, 32'h8000_003F, 1'b0, 1);
        do_write("wr_both", rand256(), 32'h1234_5678, 1'b1, 0);

        for (int i = 0; i < 3; i++) begin
            resp_i  = 1'b1;
            burst_i = rand64();
            step();
            check("stray ctrl", 256'({read_o, write_o, resp_o}), 256'(3'b000));
            check("stray line_o", line_o, m_line);
        end
        resp_i = 1'b0;

        for (int i = 0; i < 4; i++) bts[i] = rand64();
        do_write("dirty_wb", rand256(), 32'hCAFE_0040, 1'b0, 1);
        do_read("dirty_fill", 32'hCAFE_1000, bts, 1, 16'h0, 0);

        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 4; i++) bts[i] = rand64();
                do_read("rnd_rd", $urandom, bts, 1, 16'h0, 0);
            end else begin
                do_write("rnd_wr", rand256(), $urandom, 1'($urandom_range(0, 1)), 1);
            end
        end

        for (int i = 0; i < 4; i++) bts[i] = rand64();
        read_i    = 1'b1;
        address_i = 32'h0000_5000;
        step();
        for (int i = 0; i < 2; i++) begin
            resp_i  = 1'b1;
            burst_i = bts[i];
            step();
        end
        check("abort read_o before", 256'(read_o), 256'(1'b1));
        #2;
        rst = 1'b0;
        #1;
        m_line = '0;
        check("abort read_o", 256'(read_o), 256'(1'b0));
        check("abort resp_o", 256'(resp_o), 256'(1'b0));
        check("abort line_o", line_o, m_line);
        read_i = 1'b0;
        resp_i = 1'b0;
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        check("abort idle", 256'({read_o, write_o, resp_o}), 256'(3'b000));
        do_read("post_abort", 32'h0000_5010, bts, 1, 16'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Sits directly downstream of the L1 cache, between the cache's 256-bit line port and the 64-bit burst memory port.
- Reads: collects burst beats from memory, assembles them into one cache line and returns it to the cache.
- Writes (writebacks): splits a dirty line into beats and streams them out in order.
- One transaction in flight at a time, controlled by a small FSM and a beat counter.

Parameters:
- s_line, 256, cache line width in bits.
- s_burst, 64, memory burst beat width in bits.
- num_beats, s_line/s_burst (4), beats per line; derived, do not override.
- s_cnt, $clog2(num_beats) (2), beat counter width; derived.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset. Asserting it (low) forces reset state immediately, independent of clk.
- line_i  in  256  writeback line from the cache.
- address_i  in  32  request byte address from the cache.
- read_i  in  1  cache requests a line fill; held high until resp_o.
- write_i  in  1  cache requests a writeback; held high until resp_o.
- line_o  out  256  assembled fill line to the cache.
- resp_o  out  1  one-cycle completion pulse to the cache.
- burst_i  in  64  read beat from memory; valid only when resp_i=1.
- resp_i  in  1  memory beat strobe: one beat transferred per cycle it is high.
- burst_o  out  64  write beat to memory.
- address_o  out  32  line-aligned memory address.
- read_o  out  1  burst read request to memory.
- write_o  out  1  burst write request to memory.

Behaviour:
- Reset (rst=0): state=IDLE, beat counter=0, line buffer=0, address register=0. All outputs are 0: line_o, burst_o, address_o, read_o, write_o, resp_o.
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE, write_i=1: latch line_i into the buffer, latch {address_i[31:5],5'b0} into the address register, clear the counter, go to WR_BURST.
  - Write wins over read if write_i and read_i are both high.
- IDLE, read_i=1 (write_i=0): latch the aligned address, clear the counter, go to RD_BURST.
- IDLE, neither request: stay in IDLE. resp_i is ignored in IDLE, RD_DONE and WR_DONE.
- RD_BURST:
  - read_o=1; address_o = address register.
  - Each cycle with resp_i=1, store burst_i into buffer slice [64*cnt+63 : 64*cnt], then increment the counter.
  - Cycles with resp_i=0 are stalls: no change.
  - On the beat where cnt=num_beats-1, go to RD_DONE. read_o is 0 from the next cycle on.
- RD_DONE: resp_o=1 for exactly one cycle, line_o = buffer, then go to IDLE.
- WR_BURST:
  - write_o=1; address_o = address register.
  - burst_o = buffer slice [64*cnt+63 : 64*cnt] (combinational from the counter).
  - Each cycle with resp_i=1, the beat is consumed and the counter increments, so burst_o shows the next beat the following cycle.
  - Stalls hold burst_o stable.
  - On the last beat, go to WR_DONE.
- WR_DONE: resp_o=1 for one cycle, then go to IDLE.
- line_o holds the last assembled line until the next read completes. It is not cleared by a write.
- Beat order is little-endian: beat 0 = line bits [63:0], beat 3 = bits [255:192].
- Minimum latency: request seen at edge T; read_o/write_o high during cycle T+1; with 4 back-to-back beats in cycles T+1..T+4, resp_o is high in cycle T+5.
- Back-to-back requests: IDLE is always visited for at least one cycle between transactions. The cache deasserts its request on the edge ending the resp_o cycle, so no double acceptance occurs.
- Reset mid-burst: the transaction is abandoned, state returns to IDLE and the memory request drops immediately. The memory model must tolerate the aborted burst.
- Counter wrap: the counter is only cleared on acceptance, never wraps within a transaction, and is never read outside the burst states.

Test Plan:
- Reset: rst=0 mid-RD_BURST after 2 beats -> read_o=0, resp_o=0 and line_o=0 immediately; after release, IDLE and the next read completes normally.
- Read, back-to-back beats: address_i=0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp_i high 4 consecutive cycles -> address_o=0x0000_1220; line_o={0x44..,0x33..,0x22..,0x11..}; single resp_o pulse at T+5.
- Read with stalls: resp_i pattern 1,0,0,1,1,0,1 -> same line assembled; resp_o one cycle after the 4th strobe; read_o high for all 7 cycles.
- Writeback: line_i=0xDDDD..|CCCC..|BBBB..|AAAA.. (64-bit quarters), address_i=0x8000_003F -> address_o=0x8000_0020; burst_o sequence 0xAAAA..,0xBBBB..,0xCCCC..,0xDDDD.., each held until its resp_i; then resp_o pulse.
- Simultaneous read_i=write_i=1 -> write transaction runs (write_o=1, read_o=0); line_o unchanged afterwards.
- Back-to-back writeback then fill (the cache's dirty-miss sequence) -> exactly two resp_o pulses, separated by at least one IDLE cycle; stray resp_i in IDLE causes no state change.
